// File: rtl/host_pkg.sv
// rtl/host_pkg.sv - shared constants, state and line types for the host line packer
package host_pkg;

  localparam int ADDR_BITCOUNT = 64;
  localparam int WORD_SIZE     = 32;
  localparam int CL_SIZE_WIDTH = 512;
  localparam int WPL           = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int LINE_OFF_BITS = 6;
  localparam int IDX_BITS      = $clog2(WPL);
  localparam int TAG_BITS      = ADDR_BITCOUNT - LINE_OFF_BITS;

  typedef enum logic [2:0] {
    COLLECT,
    FLUSH,
    RD_REQ,
    RD_WAIT,
    RD_RESP
  } pk_state_t;

  typedef logic [CL_SIZE_WIDTH-1:0] line_t;

  function automatic logic [TAG_BITS-1:0] line_tag(input logic [ADDR_BITCOUNT-1:0] a);
    return a[ADDR_BITCOUNT-1:LINE_OFF_BITS];
  endfunction

  function automatic logic [IDX_BITS-1:0] word_idx(input logic [ADDR_BITCOUNT-1:0] a);
    return a[LINE_OFF_BITS-1:LINE_OFF_BITS-IDX_BITS];
  endfunction

endpackage

// File: rtl/cl_line_reg.sv
// rtl/cl_line_reg.sv - line data, per-word mask and tag storage for write combining
module cl_line_reg
  import host_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                we,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [WORD_SIZE-1:0] wr_data,
  output line_t               line_q,
  output logic [WPL-1:0]      mask_q,
  output logic [TAG_BITS-1:0] tag_q,
  output logic                full_after_we,
  output logic                empty
);

  logic [WPL-1:0] wr_bit;

  assign wr_bit        = WPL'(1) << wr_idx;
  assign full_after_we = &(mask_q | wr_bit);
  assign empty         = ~|mask_q;

  // Clear and write may coincide: the write then lands in the freshly emptied line.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      mask_q <= '0;
      tag_q  <= '0;
    end else begin
      if (clr) begin
        line_q <= '0;
        mask_q <= '0;
      end
      if (we) begin
        line_q[wr_idx*WORD_SIZE +: WORD_SIZE] <= wr_data;
        mask_q[wr_idx]                        <= 1'b1;
        tag_q                                 <= wr_tag;
      end
    end
  end

endmodule

// File: rtl/host_line_packer.sv
// rtl/host_line_packer.sv - write-combining word-to-cache-line bridge with flush-before-read
module host_line_packer
  import host_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [ADDR_BITCOUNT-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0]     wr_data,
  input  logic                     rd_req,
  input  logic [ADDR_BITCOUNT-1:0] rd_addr,
  input  logic                     flush,
  output logic                     req_ready,
  output logic                     rd_valid,
  output logic [WORD_SIZE-1:0]     rd_data,
  output logic                     host_we,
  output logic [ADDR_BITCOUNT-1:0] host_wr_addr,
  output line_t                    host_wr_data,
  output logic [WPL-1:0]           host_wr_mask,
  input  logic                     host_wr_ready,
  output logic                     host_re,
  output logic [ADDR_BITCOUNT-1:0] host_rd_addr,
  input  logic                     host_rd_ready,
  input  logic                     host_rd_valid,
  input  line_t                    host_rd_data,
  output logic                     idle
);

  pk_state_t state, state_n;

  logic                 pw_valid, pr_valid;
  logic [TAG_BITS-1:0]  pw_tag, pr_tag;
  logic [IDX_BITS-1:0]  pw_idx, pr_idx;
  logic [WORD_SIZE-1:0] pw_data;
  logic                 pw_set, pr_set;

  logic                 lr_clr, lr_we;
  logic [TAG_BITS-1:0]  lr_wr_tag, lr_tag;
  logic [IDX_BITS-1:0]  lr_wr_idx;
  logic [WORD_SIZE-1:0] lr_wr_data;
  logic                 lr_full_after_we, lr_empty;
  line_t                lr_line;
  logic [WPL-1:0]       lr_mask;

  logic unused_bits;
  assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0]};

  cl_line_reg u_line (
    .clk           (clk),
    .rst           (rst),
    .clr           (lr_clr),
    .we            (lr_we),
    .wr_tag        (lr_wr_tag),
    .wr_idx        (lr_wr_idx),
    .wr_data       (lr_wr_data),
    .line_q        (lr_line),
    .mask_q        (lr_mask),
    .tag_q         (lr_tag),
    .full_after_we (lr_full_after_we),
    .empty         (lr_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    lr_clr     = 1'b0;
    lr_we      = 1'b0;
    lr_wr_tag  = line_tag(wr_addr);
    lr_wr_idx  = word_idx(wr_addr);
    lr_wr_data = wr_data;
    pw_set     = 1'b0;
    pr_set     = 1'b0;
    case (state)
      COLLECT: begin
        if (wr_req) begin
          if (lr_empty || (line_tag(wr_addr) == lr_tag)) begin
            lr_we = 1'b1;
            if (lr_full_after_we || flush) state_n = FLUSH;
          end else begin
            pw_set  = 1'b1;
            state_n = FLUSH;
          end
        end else if (rd_req) begin
          pr_set  = 1'b1;
          state_n = lr_empty ? RD_REQ : FLUSH;
        end else if (flush && !lr_empty) begin
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (host_wr_ready) begin
          lr_clr = 1'b1;
          // A write that missed the old tag is replayed into the emptied line.
          if (pw_valid) begin
            lr_we      = 1'b1;
            lr_wr_tag  = pw_tag;
            lr_wr_idx  = pw_idx;
            lr_wr_data = pw_data;
          end
          state_n = pr_valid ? RD_REQ : COLLECT;
        end
      end
      RD_REQ:  if (host_rd_ready) state_n = RD_WAIT;
      RD_WAIT: if (host_rd_valid) state_n = RD_RESP;
      RD_RESP: state_n = COLLECT;
      default: state_n = COLLECT;
    endcase
  end

  always_comb begin
    req_ready = (state == COLLECT);
    host_we   = (state == FLUSH);
    host_re   = (state == RD_REQ);
    rd_valid  = (state == RD_RESP);
    idle      = (state == COLLECT) && lr_empty;
  end

  assign host_wr_addr = {lr_tag, {LINE_OFF_BITS{1'b0}}};
  assign host_wr_data = lr_line;
  assign host_wr_mask = lr_mask;
  assign host_rd_addr = {pr_tag, {LINE_OFF_BITS{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      pw_valid <= 1'b0;
      pw_tag   <= '0;
      pw_idx   <= '0;
      pw_data  <= '0;
      pr_valid <= 1'b0;
      pr_tag   <= '0;
      pr_idx   <= '0;
      rd_data  <= '0;
    end else begin
      if (pw_set) begin
        pw_valid <= 1'b1;
        pw_tag   <= line_tag(wr_addr);
        pw_idx   <= word_idx(wr_addr);
        pw_data  <= wr_data;
      end else if (state == FLUSH && host_wr_ready) begin
        pw_valid <= 1'b0;
      end
      if (pr_set) begin
        pr_valid <= 1'b1;
        pr_tag   <= line_tag(rd_addr);
        pr_idx   <= word_idx(rd_addr);
      end else if (state == RD_RESP) begin
        pr_valid <= 1'b0;
      end
      if (state == RD_WAIT && host_rd_valid)
        rd_data <= host_rd_data[pr_idx*WORD_SIZE +: WORD_SIZE];
    end
  end

endmodule

// File: tb/tb_host_line_packer.sv
// tb/tb_host_line_packer.sv - scoreboard bench with word-memory reference model and host responder
module tb_host_line_packer;
  import host_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0, rd_req = 1'b0, flush = 1'b0;
  logic [63:0] wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic        req_ready, rd_valid, host_we, host_re, idle;
  logic [31:0] rd_data;
  logic [63:0] host_wr_addr, host_rd_addr;
  line_t       host_wr_data;
  logic [15:0] host_wr_mask;
  logic        host_wr_ready = 1'b0, host_rd_ready = 1'b0, host_rd_valid = 1'b0;
  line_t       host_rd_data = '0;

  always #5 clk = ~clk;

  host_line_packer dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .flush(flush), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .host_we(host_we), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_wr_mask(host_wr_mask), .host_wr_ready(host_wr_ready),
    .host_re(host_re), .host_rd_addr(host_rd_addr), .host_rd_ready(host_rd_ready),
    .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data), .idle(idle)
  );

  typedef struct {
    logic [63:0] addr;
    line_t       data;
    logic [15:0] mask;
  } wexp_t;

  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = 0, last_lat = 0, we_len = 0, last_we_len = 0;
  int wr_stall = 0, rd_cnt = 0;
  bit fast = 1'b1, hold_rd = 1'b0, rd_pend = 1'b0;
  logic [57:0] rd_tag;

  wexp_t       exp_wr[$];
  logic [31:0] exp_rd[$];

  // Reference: a flat word memory plus the one open write-combining line.
  logic [31:0] wmem[logic [63:0]];
  line_t       hmem[logic [57:0]];
  logic [57:0] m_tag = '0;
  logic [31:0] m_words[16];
  logic [15:0] m_mask = '0;

  logic [63:0] cap_addr;
  line_t       cap_data;
  logic [15:0] cap_mask;
  wexp_t       he;
  line_t       hl;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [31:0] dflt_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  function automatic line_t get_line(input logic [57:0] t);
    line_t l;
    if (hmem.exists(t)) return hmem[t];
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = dflt_word({t, 4'(i), 2'b00});
    return l;
  endfunction

  task automatic m_push_flush();
    wexp_t e;
    if (m_mask != 16'h0) begin
      e.addr = {m_tag, 6'b0};
      e.mask = m_mask;
      e.data = '0;
      for (int i = 0; i < 16; i++) if (m_mask[i]) e.data[i*32 +: 32] = m_words[i];
      exp_wr.push_back(e);
      m_mask = '0;
    end
  endtask

  task automatic m_write(input logic [63:0] a, input logic [31:0] d);
    wmem[{a[63:2], 2'b00}] = d;
    if (m_mask != 16'h0 && a[63:6] != m_tag) m_push_flush();
    m_tag = a[63:6];
    m_words[a[5:2]] = d;
    m_mask[a[5:2]] = 1'b1;
    if (&m_mask) m_push_flush();
  endtask

  task automatic m_read(input logic [63:0] a);
    logic [63:0] k;
    k = {a[63:2], 2'b00};
    m_push_flush();
    exp_rd.push_back(wmem.exists(k) ? wmem[k] : dflt_word(k));
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail_now({nm, "_req_ready_timeout"});
  endtask

  task automatic do_op(input bit w, input bit r, input bit f, input logic [63:0] aw,
                       input logic [31:0] d, input logic [63:0] ar);
    @(negedge clk);
    wr_req = w; wr_addr = aw; wr_data = d; rd_req = r; rd_addr = ar; flush = f;
    wait_ready("op");
    acc_cyc = cyc;
    if (w) m_write(aw, d);
    else if (r) m_read(ar);
    else if (f) m_push_flush();
    @(negedge clk);
    wr_req = 1'b0; flush = 1'b0;
    if (w && r) begin
      wait_ready("held_read");
      acc_cyc = cyc;
      m_read(ar);
      @(negedge clk);
    end
    rd_req = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || !req_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_wr_queue_empty"}, 512'(exp_wr.size()), 512'(0));
    chk({nm, "_rd_queue_empty"}, 512'(exp_rd.size()), 512'(0));
  endtask

  // Host model and output monitor share the negedge so every sample is away from posedge.
  always @(negedge clk) begin
    if (rst) begin
      rd_pend = 1'b0;
      host_rd_valid = 1'b0;
      we_len = 0;
    end else begin
      if (rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_valid_unexpected", 512'(rd_valid), 512'(0));
        else chk("rd_data", 512'(rd_data), 512'(exp_rd.pop_front()));
        last_lat = cyc - acc_cyc;
      end
      host_rd_valid = 1'b0;
      if (rd_pend) begin
        if (!hold_rd) begin
          if (rd_cnt == 0) begin
            host_rd_valid = 1'b1;
            host_rd_data = get_line(rd_tag);
            rd_pend = 1'b0;
          end else rd_cnt--;
        end
      end else if (!fast && $urandom_range(0, 7) == 0) begin
        host_rd_valid = 1'b1;
        host_rd_data = {16{$urandom()}};
      end
      if (host_we && wr_stall > 0) begin
        host_wr_ready = 1'b0;
        wr_stall--;
      end else host_wr_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
      host_rd_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (host_we) begin
        if (we_len == 0) begin
          cap_addr = host_wr_addr; cap_data = host_wr_data; cap_mask = host_wr_mask;
        end else begin
          chk("we_addr_stable", 512'(host_wr_addr), 512'(cap_addr));
          chk("we_data_stable", host_wr_data, cap_data);
          chk("we_mask_stable", 512'(host_wr_mask), 512'(cap_mask));
        end
        chk("req_ready_in_flush", 512'(req_ready), 512'(0));
        we_len++;
        if (host_wr_ready) begin
          last_we_len = we_len;
          we_len = 0;
          if (exp_wr.size() == 0) chk("host_we_unexpected", 512'(host_we), 512'(0));
          else begin
            he = exp_wr.pop_front();
            chk("host_wr_addr", 512'(host_wr_addr), 512'(he.addr));
            chk("host_wr_mask", 512'(host_wr_mask), 512'(he.mask));
            chk("host_wr_data", host_wr_data, he.data);
          end
          hl = get_line(host_wr_addr[63:6]);
          for (int i = 0; i < 16; i++)
            if (host_wr_mask[i]) hl[i*32 +: 32] = host_wr_data[i*32 +: 32];
          hmem[host_wr_addr[63:6]] = hl;
        end
      end
      if (host_re) begin
        chk("flush_before_read", 512'(exp_wr.size()), 512'(0));
        if (host_rd_ready && !rd_pend) begin
          rd_pend = 1'b1;
          rd_cnt = fast ? 0 : int'($urandom_range(0, 2));
          rd_tag = host_rd_addr[63:6];
        end
      end
    end
  end

  logic [63:0] tags[4];
  logic [63:0] ra, rb;
  int          op;

  initial begin
    tags = '{64'h1000, 64'h1040, 64'h2000, 64'hFFFF_FFFF_FFFF_FFC0};
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 512'(req_ready), 512'(1));
    chk("rst_idle", 512'(idle), 512'(1));
    chk("rst_rd_valid", 512'(rd_valid), 512'(0));
    chk("rst_host_we", 512'(host_we), 512'(0));
    chk("rst_host_re", 512'(host_re), 512'(0));
    chk("rst_rd_data", 512'(rd_data), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 512'(idle), 512'(1));

    for (int i = 0; i < 16; i++) do_op(1, 0, 0, 64'h1000 + 64'(4 * i), 32'(i), '0);
    drain("full_line");
    chk("full_line_idle", 512'(idle), 512'(1));

    do_op(1, 0, 0, 64'h1000, 32'h11, '0);
    do_op(1, 0, 0, 64'h1004, 32'h22, '0);
    do_op(1, 0, 0, 64'h1008, 32'h33, '0);
    do_op(1, 0, 0, 64'h2010, 32'h44, '0);
    do_op(0, 0, 1, '0, '0, '0);
    drain("tag_miss");

    do_op(1, 0, 0, 64'h3004, 32'hA, '0);
    do_op(1, 0, 0, 64'h3004, 32'hB, '0);
    do_op(0, 0, 1, '0, '0, '0);
    drain("overwrite");

    do_op(1, 0, 0, 64'h4000, 32'h55, '0);
    do_op(0, 1, 0, '0, '0, 64'h4000);
    drain("read_after_write");

    do_op(0, 1, 0, '0, '0, 64'h5008);
    drain("latency");
    chk("rd_latency", 512'(last_lat), 512'(3));

    wr_stall = 5;
    do_op(1, 0, 0, 64'h6000, 32'h66, '0);
    do_op(0, 0, 1, '0, '0, '0);
    drain("stall");
    chk("stall_we_cycles", 512'(last_we_len), 512'(6));

    fast = 1'b0;
    for (int n = 0; n < 400; n++) begin
      ra = tags[$urandom_range(0, 3)] | (64'($urandom_range(0, 15)) << 2) | 64'($urandom_range(0, 3));
      rb = tags[$urandom_range(0, 3)] | (64'($urandom_range(0, 15)) << 2);
      op = int'($urandom_range(0, 9));
      if (op < 5)       do_op(1, 0, 0, ra, $urandom(), '0);
      else if (op < 7)  do_op(0, 1, 0, '0, '0, rb);
      else if (op == 7) do_op(1, 1, 0, ra, $urandom(), rb);
      else if (op == 8) do_op(0, 0, 1, '0, '0, '0);
      else @(negedge clk);
    end
    do_op(0, 0, 1, '0, '0, '0);
    drain("random");
    chk("random_idle", 512'(idle), 512'(1));

    fast = 1'b1;
    hold_rd = 1'b1;
    do_op(0, 1, 0, '0, '0, 64'h7000);
    for (int n = 0; n < 100 && !rd_pend; n++) @(negedge clk);
    if (!rd_pend) fail_now("rd_wait_entry_timeout");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rdwait_host_re", 512'(host_re), 512'(0));
    chk("rst_rdwait_idle", 512'(idle), 512'(1));
    chk("rst_rdwait_req_ready", 512'(req_ready), 512'(1));
    chk("rst_rdwait_rd_valid", 512'(rd_valid), 512'(0));
    chk("rst_rdwait_rd_data", 512'(rd_data), 512'(0));
    exp_rd.delete();
    rd_pend = 1'b0;
    hold_rd = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("after_rst_idle", 512'(idle), 512'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/host_line_packer.md
Name: host_line_packer

Overview:
- Sits between mem_ctrl's word-side request path and the host cache-line interface.
- Write-combines 32-bit word writes into one 512-bit line buffer with a per-word valid mask, and flushes that line to the host.
- Serves word reads by fetching a full line from the host and extracting the addressed word.
- Flushes any buffered data before every host read, so reads always observe prior writes.

Parameters:
ADDR_BITCOUNT, 64, byte address width
WORD_SIZE, 32, word width in bits
CL_SIZE_WIDTH, 512, cache-line width in bits; words per line WPL = CL_SIZE_WIDTH/WORD_SIZE = 16

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
wr_req  in  1  word write request
wr_addr  in  ADDR_BITCOUNT  write byte address; [1:0] ignored
wr_data  in  WORD_SIZE  write data
rd_req  in  1  word read request
rd_addr  in  ADDR_BITCOUNT  read byte address
flush  in  1  force out the buffered line
req_ready  out  1  word request accepted this cycle when high
rd_valid  out  1  one-cycle pulse; rd_data valid
rd_data  out  WORD_SIZE  read data
host_we  out  1  host line write request
host_wr_addr  out  ADDR_BITCOUNT  line-aligned address ([5:0]=0)
host_wr_data  out  CL_SIZE_WIDTH  line data; word i at bits [32i+31:32i]
host_wr_mask  out  WPL  per-word valid mask
host_wr_ready  in  1  host accepts write this cycle
host_re  out  1  host line read request
host_rd_addr  out  ADDR_BITCOUNT  line-aligned read address
host_rd_ready  in  1  host accepts read request this cycle
host_rd_valid  in  1  host_rd_data valid
host_rd_data  in  CL_SIZE_WIDTH  returned line
idle  out  1  high in COLLECT with mask==0

Behaviour:
- Reset, and the cycle after rst: state=COLLECT, mask=0, pending op cleared, req_ready=1, rd_valid/host_we/host_re=0, rd_data=0, idle=1.
- Reset mid-operation (any state) discards the buffered line and any outstanding host transaction. No flush occurs.
- Line tag = addr[63:6]. Word index = addr[5:2].
- States:
  - COLLECT: req_ready=1.
  - FLUSH: host_we=1 with stable addr/data/mask until host_wr_ready.
  - RD_REQ: host_re=1 with stable addr until host_rd_ready.
  - RD_WAIT: wait for host_rd_valid.
  - RD_RESP: rd_valid=1 for exactly one cycle.
- req_ready=0 in every state except COLLECT.
- Acceptance rules:
  - Write accepted when wr_req & req_ready.
  - Read accepted when rd_req & ~wr_req & req_ready.
  - If wr_req and rd_req are both high, the write wins and the read must be held.
- Write in COLLECT:
  - mask==0: load tag, store word, set its mask bit.
  - Same tag: store word, overwriting any existing value; set its mask bit.
  - New mask==all-ones: go to FLUSH next cycle.
  - Different tag with mask!=0: latch the write as pending and go to FLUSH. After the flush completes, apply the pending write to the emptied buffer and return to COLLECT.
- flush in COLLECT:
  - mask!=0: go to FLUSH.
  - mask==0: no-op.
  - flush together with an accepted write: apply the write first, then flush.
- FLUSH completes on host_wr_ready:
  - Clear mask.
  - Next state is RD_REQ if a pending read exists, otherwise COLLECT.
- Read in COLLECT:
  - mask!=0: latch the read as pending and go to FLUSH.
  - mask==0: go directly to RD_REQ.
- Read completion:
  - RD_WAIT stays until host_rd_valid.
  - On host_rd_valid, register word[rd_addr[5:2]] into rd_data and go to RD_RESP.
  - RD_RESP returns to COLLECT.
- Latency: read with an empty buffer and zero-wait host gives rd_valid 3 cycles after acceptance.
- host_rd_valid outside RD_WAIT is ignored. host_wr_ready outside FLUSH is ignored.
- Unwritten words in host_wr_data are 0; the host must honour the mask.

Decomposition:
- host_pkg holds:
  - ADDR_BITCOUNT, WORD_SIZE, CL_SIZE_WIDTH, WPL and LINE_OFF_BITS=6 constants.
  - Typedef pk_state_t {COLLECT, FLUSH, RD_REQ, RD_WAIT, RD_RESP}.
  - Typedef line_t (logic [CL_SIZE_WIDTH-1:0]).
- One sub-module: cl_line_reg. It holds the line data, mask and tag registers, and provides write-word, clear, and full flag.
- The FSM stays in host_line_packer.

Test Plan:
- 16 writes, data=i, to 0x1000+4i -> exactly one host_we with addr 0x1000, mask 0xFFFF, lane i=i. idle=1 afterwards.
- 3 writes to 0x1000/0x1004/0x1008, then a write to 0x2010 -> flush of 0x1000 with mask 0x0007. Buffer then holds tag 0x2010>>6 with mask 0x0010.
- Write 0xA to 0x3004, write 0xB to 0x3004, then flush -> host_wr_data lane1=0xB, mask 0x0002.
- Write to 0x4000, then read 0x4000 -> host_we completes before host_re rises. Host returns a line with lane0=0x55 -> rd_valid pulse with rd_data=0x55.
- host_wr_ready held low 5 cycles during FLUSH -> host_we, addr, data and mask stable. req_ready=0 throughout. Completes on cycle 6.
- rst asserted in RD_WAIT -> next cycle: state COLLECT, host_re=0, rd_valid never pulses, idle=1.
